// File: rtl/cfg_reg_bank.sv
// Bank of NUM_REGS configuration/status registers behind a valid/ack bus.
// Each register is RW, RO (live input), W1C status, or WSC self-clearing pulse.
module cfg_reg_bank #(
    parameter int NUM_REGS       = 8,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter logic [REG_ADDR_WIDTH-1:0]          BASE_ADDR   = '0,
    parameter logic [NUM_REGS*REG_DATA_WIDTH-1:0] INIT_VALUES = '0,
    parameter logic [NUM_REGS*2-1:0]              REG_TYPES   = '0
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               wr_vld,
    input  logic [REG_ADDR_WIDTH-1:0]          wr_addr,
    input  logic [REG_DATA_WIDTH-1:0]          wr_data,
    output logic                               wr_ack,
    output logic                               wr_err,
    input  logic                               rd_vld,
    input  logic [REG_ADDR_WIDTH-1:0]          rd_addr,
    output logic                               rd_ack,
    output logic [REG_DATA_WIDTH-1:0]          rd_data,
    output logic                               rd_err,
    input  logic [NUM_REGS*REG_DATA_WIDTH-1:0] ro_data,
    input  logic [NUM_REGS*REG_DATA_WIDTH-1:0] hw_set,
    output logic [NUM_REGS*REG_DATA_WIDTH-1:0] reg_data,
    output logic [NUM_REGS-1:0]                wr_pulse
);

    localparam int W  = REG_DATA_WIDTH;
    localparam int AW = REG_ADDR_WIDTH;
    localparam logic [1:0] T_RW  = 2'd0;
    localparam logic [1:0] T_RO  = 2'd1;
    localparam logic [1:0] T_W1C = 2'd2;
    localparam logic [1:0] T_WSC = 2'd3;
    localparam logic [AW-1:0] NUM_REGS_A = AW'(NUM_REGS);

    // Offset is forced to zero below the base so the subtraction never wraps.
    function automatic logic [AW-1:0] addr_off(input logic [AW-1:0] addr);
        return (addr >= BASE_ADDR) ? (addr - BASE_ADDR) : '0;
    endfunction

    function automatic logic addr_ok(input logic [AW-1:0] addr);
        logic [AW-1:0] off;
        off = addr_off(addr);
        return (addr >= BASE_ADDR) && (off[1:0] == 2'b00) && ((off >> 2) < NUM_REGS_A);
    endfunction

    logic [W-1:0]        q     [NUM_REGS];
    logic [W-1:0]        q_nxt [NUM_REGS];
    logic [W-1:0]        cur   [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] rd_hit;
    logic [NUM_REGS-1:0] ro_mask;
    logic [NUM_REGS-1:0] wr_ok;
    logic                wr_addr_ok;
    logic                rd_addr_ok;
    logic [AW-1:0]       wr_word;
    logic [AW-1:0]       rd_word;
    logic [W-1:0]        rd_val;
    logic                wr_err_nxt;

    always_comb begin
        wr_addr_ok = addr_ok(wr_addr);
        rd_addr_ok = addr_ok(rd_addr);
        wr_word    = addr_off(wr_addr) >> 2;
        rd_word    = addr_off(rd_addr) >> 2;
        rd_val     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ro_mask[i] = (REG_TYPES[i*2 +: 2] == T_RO);
            wr_hit[i]  = wr_vld && wr_addr_ok && (wr_word == AW'(i));
            rd_hit[i]  = rd_vld && rd_addr_ok && (rd_word == AW'(i));
            wr_ok[i]   = wr_hit[i] && !ro_mask[i];
            cur[i]     = ro_mask[i] ? ro_data[i*W +: W] : q[i];
            if (rd_hit[i]) rd_val = cur[i];
        end
        wr_err_nxt = wr_vld && (!wr_addr_ok || (|(wr_hit & ro_mask)));
    end

    // hw_set beats a same-cycle W1C clear; WSC falls back to its reset value.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            q_nxt[i] = q[i];
            case (REG_TYPES[i*2 +: 2])
                T_RW:    if (wr_ok[i]) q_nxt[i] = wr_data;
                T_W1C:   q_nxt[i] = (wr_ok[i] ? (q[i] & ~wr_data) : q[i]) | hw_set[i*W +: W];
                T_WSC:   q_nxt[i] = wr_ok[i] ? wr_data : INIT_VALUES[i*W +: W];
                default: q_nxt[i] = q[i];
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_data[g*W +: W] = cur[g];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) q[i] <= INIT_VALUES[i*W +: W];
            wr_ack   <= 1'b0;
            wr_err   <= 1'b0;
            rd_ack   <= 1'b0;
            rd_err   <= 1'b0;
            rd_data  <= '0;
            wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) q[i] <= q_nxt[i];
            wr_ack   <= wr_vld;
            wr_err   <= wr_err_nxt;
            rd_ack   <= rd_vld;
            rd_err   <= rd_vld && !rd_addr_ok;
            rd_data  <= rd_val;
            wr_pulse <= wr_ok;
        end
    end

endmodule

// File: tb/tb_cfg_reg_bank.sv
// Bench for cfg_reg_bank: requests push expected acks to queues, a negedge
// monitor pops them; per-scenario tasks also check register contents inline.
module tb_cfg_reg_bank;

    localparam int N  = 8;
    localparam int W  = 32;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] RO_VAL = 32'h1234_5678;
    localparam logic [N*W-1:0] INIT = {32'h0, 32'h0, 32'h5555_0005, 32'h0000_00F0,
                                       32'h0, 32'h0, 32'h0, 32'hA5A5_0001};
    // reg2 W1C, reg3 RO, reg4 WSC, rest RW
    localparam logic [N*2-1:0] TYPES = 16'b00_00_00_11_01_10_00_00;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           wr_vld = 1'b0;
    logic [31:0]    wr_addr = '0;
    logic [31:0]    wr_data = '0;
    logic           wr_ack, wr_err;
    logic           rd_vld = 1'b0;
    logic [31:0]    rd_addr = '0;
    logic           rd_ack, rd_err;
    logic [31:0]    rd_data;
    logic [N*W-1:0] ro_data = '0;
    logic [N*W-1:0] hw_set = '0;
    logic [N*W-1:0] reg_data;
    logic [N-1:0]   wr_pulse;

    cfg_reg_bank #(
        .NUM_REGS(N), .REG_ADDR_WIDTH(32), .REG_DATA_WIDTH(W),
        .BASE_ADDR(BASE), .INIT_VALUES(INIT), .REG_TYPES(TYPES)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_err(wr_err),
        .rd_vld(rd_vld), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err),
        .ro_data(ro_data), .hw_set(hw_set),
        .reg_data(reg_data), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        wq[$];
    exp_t        rq[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] mdl [N];

    always @(posedge clk) cyc++;

    function automatic logic [31:0] exp_reg(input int i);
        return (i == 3) ? RO_VAL : mdl[i];
    endfunction

    // scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            total++;
            if (wq.size() > 0 && wq[0].due == cyc) begin
                e = wq.pop_front();
                if (wr_ack !== 1'b1 || wr_err !== e.err) begin
                    bad++;
                    $display("FAIL wr_resp cyc=%0d: got ack=%b err=%b, want ack=1 err=%b",
                             cyc, wr_ack, wr_err, e.err);
                end
            end else if (wr_ack !== 1'b0) begin
                bad++;
                $display("FAIL wr_spurious cyc=%0d: got ack=%b, want ack=0", cyc, wr_ack);
            end
            total++;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e = rq.pop_front();
                if (rd_ack !== 1'b1 || rd_err !== e.err || rd_data !== e.data) begin
                    bad++;
                    $display("FAIL rd_resp cyc=%0d: got ack=%b err=%b data=%h, want ack=1 err=%b data=%h",
                             cyc, rd_ack, rd_err, rd_data, e.err, e.data);
                end
            end else if (rd_ack !== 1'b0) begin
                bad++;
                $display("FAIL rd_spurious cyc=%0d: got ack=%b, want ack=0", cyc, rd_ack);
            end
        end
    end

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic err);
        wr_vld = 1'b1; wr_addr = a; wr_data = d;
        wq.push_back('{due: cyc + 1, data: 32'h0, err: err});
    endtask

    task automatic rd_req(input logic [31:0] a, input logic [31:0] d, input logic err);
        rd_vld = 1'b1; rd_addr = a;
        rq.push_back('{due: cyc + 1, data: d, err: err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        rd_vld = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) mdl[i] = INIT[i*W +: W];
        ro_data[3*W +: W] = RO_VAL;
        ro_data[7*W +: W] = 32'hFFFF_FFFF;
        rstn = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < N; i++) begin
            total++;
            if (reg_data[i*W +: W] !== exp_reg(i)) begin
                bad++;
                $display("FAIL reset_reg%0d: got %h, want %h", i, reg_data[i*W +: W], exp_reg(i));
            end
        end
        total++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0 || rd_data !== 32'h0 || wr_pulse !== '0) begin
            bad++;
            $display("FAIL reset_outs: got acks/errs=%b rd_data=%h pulse=%b, want 0",
                     {wr_ack, wr_err, rd_ack, rd_err}, rd_data, wr_pulse);
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_rw();
        wr_req(BASE + 32'h4, 32'hDEAD_BEEF, 1'b0);
        tick();
        mdl[1] = 32'hDEAD_BEEF;
        total++;
        if (reg_data[1*W +: W] !== 32'hDEAD_BEEF || wr_pulse !== 8'b0000_0010) begin
            bad++;
            $display("FAIL rw_write: got reg1=%h pulse=%b, want reg1=deadbeef pulse=00000010",
                     reg_data[1*W +: W], wr_pulse);
        end
        rd_req(BASE + 32'h4, 32'hDEAD_BEEF, 1'b0);
        tick();
        total++;
        if (wr_pulse !== 8'h00) begin
            bad++;
            $display("FAIL rw_pulse_len: got pulse=%b, want 0", wr_pulse);
        end
        rd_req(BASE, 32'hA5A5_0001, 1'b0);
        tick();
        rd_req(BASE + 32'h1C, 32'h0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_errors();
        wr_req(BASE + 32'h2, 32'h0BAD_0BAD, 1'b1);
        tick();
        wr_req(BASE + 32'h20, 32'h0BAD_0BAD, 1'b1);
        tick();
        total++;
        if (wr_pulse !== 8'h00) begin
            bad++;
            $display("FAIL err_pulse: got pulse=%b, want 0", wr_pulse);
        end
        wr_req(BASE - 32'h4, 32'h0BAD_0BAD, 1'b1);
        rd_req(BASE + 32'h2, 32'h0, 1'b1);
        tick();
        rd_req(BASE + 32'h20, 32'h0, 1'b1);
        tick();
        rd_req(BASE - 32'h4, 32'h0, 1'b1);
        tick();
        for (int i = 0; i < N; i++) begin
            total++;
            if (reg_data[i*W +: W] !== exp_reg(i)) begin
                bad++;
                $display("FAIL err_nochange_reg%0d: got %h, want %h", i, reg_data[i*W +: W], exp_reg(i));
            end
        end
        tick();
    endtask

    task automatic test_w1c();
        hw_set[2*W +: W] = 32'h0000_0003;
        hw_set[0*W +: W] = 32'hFFFF_FFFF;
        tick();
        hw_set = '0;
        tick();
        total++;
        if (reg_data[2*W +: W] !== 32'h3 || reg_data[0*W +: W] !== mdl[0]) begin
            bad++;
            $display("FAIL w1c_set: got reg2=%h reg0=%h, want reg2=00000003 reg0=%h",
                     reg_data[2*W +: W], reg_data[0*W +: W], mdl[0]);
        end
        wr_req(BASE + 32'h8, 32'h1, 1'b0);
        hw_set[2*W +: W] = 32'h1;
        tick();
        hw_set = '0;
        total++;
        if (reg_data[2*W +: W] !== 32'h3 || wr_pulse !== 8'b0000_0100) begin
            bad++;
            $display("FAIL w1c_set_wins: got reg2=%h pulse=%b, want 00000003 00000100",
                     reg_data[2*W +: W], wr_pulse);
        end
        wr_req(BASE + 32'h8, 32'h3, 1'b0);
        tick();
        total++;
        if (reg_data[2*W +: W] !== 32'h0) begin
            bad++;
            $display("FAIL w1c_clear: got reg2=%h, want 00000000", reg_data[2*W +: W]);
        end
        rd_req(BASE + 32'h8, 32'h0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_ro_wsc();
        wr_req(BASE + 32'hC, 32'hFFFF_FFFF, 1'b1);
        tick();
        total++;
        if (reg_data[3*W +: W] !== RO_VAL || wr_pulse !== 8'h00) begin
            bad++;
            $display("FAIL ro_write: got reg3=%h pulse=%b, want %h 00000000",
                     reg_data[3*W +: W], wr_pulse, RO_VAL);
        end
        rd_req(BASE + 32'hC, RO_VAL, 1'b0);
        tick();
        wr_req(BASE + 32'h10, 32'h1, 1'b0);
        tick();
        total++;
        if (reg_data[4*W +: W] !== 32'h1 || wr_pulse !== 8'b0001_0000) begin
            bad++;
            $display("FAIL wsc_write: got reg4=%h pulse=%b, want 00000001 00010000",
                     reg_data[4*W +: W], wr_pulse);
        end
        rd_req(BASE + 32'h10, 32'h1, 1'b0);
        tick();
        total++;
        if (reg_data[4*W +: W] !== 32'h0000_00F0) begin
            bad++;
            $display("FAIL wsc_return: got reg4=%h, want 000000f0", reg_data[4*W +: W]);
        end
        rd_req(BASE + 32'h10, 32'h0000_00F0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        wr_req(BASE + 32'h4, 32'h1111_1111, 1'b0);
        rd_req(BASE + 32'h4, mdl[1], 1'b0);
        tick();
        total++;
        if (reg_data[1*W +: W] !== 32'h1111_1111 || wr_pulse !== 8'b0000_0010) begin
            bad++;
            $display("FAIL b2b_first: got reg1=%h pulse=%b, want 11111111 00000010",
                     reg_data[1*W +: W], wr_pulse);
        end
        wr_req(BASE + 32'h4, 32'h2222_2222, 1'b0);
        rd_req(BASE + 32'h4, 32'h1111_1111, 1'b0);
        tick();
        wr_req(BASE, 32'h3333_3333, 1'b0);
        rd_req(BASE + 32'h4, 32'h2222_2222, 1'b0);
        tick();
        rd_req(BASE, 32'h3333_3333, 1'b0);
        tick();
        tick();
        // burst interrupted by reset before its acks are checked
        wr_vld = 1'b1; wr_addr = BASE + 32'h4; wr_data = 32'h4444_4444;
        rd_vld = 1'b1; rd_addr = BASE + 32'h4;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) mdl[i] = INIT[i*W +: W];
        total++;
        if ({wr_ack, wr_err, rd_ack, rd_err} !== 4'b0 || wr_pulse !== '0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_acks: got acks/errs=%b pulse=%b rd_data=%h, want 0",
                     {wr_ack, wr_err, rd_ack, rd_err}, wr_pulse, rd_data);
        end
        for (int i = 0; i < N; i++) begin
            total++;
            if (reg_data[i*W +: W] !== exp_reg(i)) begin
                bad++;
                $display("FAIL rst_reg%0d: got %h, want %h", i, reg_data[i*W +: W], exp_reg(i));
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (wr_ack !== 1'b0 || rd_ack !== 1'b0) begin
            bad++;
            $display("FAIL rst_hold: got wr_ack=%b rd_ack=%b, want 0", wr_ack, rd_ack);
        end
        wr_vld = 1'b0;
        rd_vld = 1'b0;
        rstn = 1'b1;
        tick();
        rd_req(BASE + 32'h4, 32'h0, 1'b0);
        tick();
        rd_req(BASE, 32'hA5A5_0001, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_rw();
        test_errors();
        test_w1c();
        test_ro_wsc();
        test_back_to_back();
        repeat (2) tick();
        total++;
        if (wq.size() != 0 || rq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got wq=%0d rq=%0d pending, want 0", wq.size(), rq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
